// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and NUM_RD combinational read ports.
// Optional write-to-read forwarding is enabled by defining REG_FILE_SB_BYPASS_EN.

module reg_file_sb_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                    raddr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
  input  logic [(2**ADDR_W)-1:0]               busy,
  input  logic                                 fwd_vld,
  input  logic [ADDR_W-1:0]                    fwd_addr,
  input  logic [DATA_W-1:0]                    fwd_data,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 rbusy
);
  logic hit;

  // A forwarded write is about to land, so the register is no longer pending.
  assign hit   = fwd_vld && (fwd_addr == raddr);
  assign rdata = hit ? fwd_data : regs[raddr];
  assign rbusy = hit ? 1'b0 : busy[raddr];
endmodule

module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  output logic [ADDR_W:0]            busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;
  logic                         wr_hit, iss_hit, cnt_inc, cnt_dec, fwd_vld;

  assign wr_hit  = we && (waddr != '0);
  assign iss_hit = iss_valid && (iss_rd != '0);

  // Clear before set so a same-cycle new producer keeps the register pending.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_hit) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (iss_hit) busy_d[iss_rd] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // inc needs a clean target and dec a busy one, so they never hit the same register.
  always_comb begin
    cnt_inc    = iss_hit && !busy_q[iss_rd];
    cnt_dec    = wr_hit && busy_q[waddr] && !(iss_hit && (iss_rd == waddr));
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec)      busy_cnt_d = busy_cnt_q + (ADDR_W+1)'(1);
    else if (cnt_dec && !cnt_inc) busy_cnt_d = busy_cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  assign fwd_vld = wr_hit && !reset;
`else
  assign fwd_vld = 1'b0;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    reg_file_sb_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .raddr    (raddr[i*ADDR_W +: ADDR_W]),
      .regs     (regs_q),
      .busy     (busy_q),
      .fwd_vld  (fwd_vld),
      .fwd_addr (waddr),
      .fwd_data (wdata),
      .rdata    (rdata[i*DATA_W +: DATA_W]),
      .rbusy    (rbusy[i])
    );
  end

  assign busy_cnt = busy_cnt_q;
endmodule
